// File: rtl/lsu_pkg.sv
// Shared encodings, tracking-entry layout and data-lane helpers for the MEM-stage load/store unit.
package lsu_pkg;

   localparam int unsigned TAG_W = 5;

   localparam logic [2:0] LSU_LB  = 3'd0;
   localparam logic [2:0] LSU_LBU = 3'd1;
   localparam logic [2:0] LSU_LH  = 3'd2;
   localparam logic [2:0] LSU_LHU = 3'd3;
   localparam logic [2:0] LSU_LW  = 3'd4;
   localparam logic [2:0] LSU_SB  = 3'd5;
   localparam logic [2:0] LSU_SH  = 3'd6;
   localparam logic [2:0] LSU_SW  = 3'd7;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;

   // kill must stay the LSB: the tracking FIFO flags it in place on flush
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [2:0]       op;
      logic [1:0]       off;
      logic             kill;
   } trk_entry_t;

   localparam int unsigned TRK_W = $bits(trk_entry_t);

   function automatic logic op_is_store(input logic [2:0] op);
      return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
   endfunction

   function automatic logic [1:0] op_size(input logic [2:0] op);
      case (op)
         LSU_LB, LSU_LBU, LSU_SB: return SIZE_B;
         LSU_LH, LSU_LHU, LSU_SH: return SIZE_H;
         default:                 return SIZE_W;
      endcase
   endfunction

   function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
      case (op_size(op))
         SIZE_H:  return off[0];
         SIZE_W:  return off != 2'd0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [31:0] wdata);
      case (op_size(op))
         SIZE_B:  return {4{wdata[7:0]}};
         SIZE_H:  return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   // Little-endian lane pick followed by sign/zero extension
   function automatic logic [31:0] load_align(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         LSU_LB:  return {{24{b[7]}}, b};
         LSU_LBU: return {24'd0, b};
         LSU_LH:  return {{16{h[15]}}, h};
         LSU_LHU: return {16'd0, h};
         default: return rdata;
      endcase
   endfunction

endpackage

// File: rtl/lsu_track_fifo.sv
// Circular FIFO tracking accepted-but-unanswered bus accesses; bit 0 of each entry is its kill flag.
module lsu_track_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             kill_all,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & !empty;
   assign do_push = push & (!full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; occupancy is governed by the pointers
   always_ff @(posedge clk) begin
      if (kill_all) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i][0] <= 1'b1;
      end
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mem_lsu_pipe.sv
// MEM-stage load/store unit: issues one SRAM-like bus access at a time, tracks up to OUTSTANDING
// in flight, aligns load data and flags misaligned accesses; flush drains in-flight accesses silently.
module mem_lsu_pipe
   import lsu_pkg::*;
#(
   parameter int unsigned        ADDR_W      = 32,
   parameter int unsigned        OUTSTANDING = 2,
   parameter logic [ADDR_W-1:0]  ADDR_MASK   = ADDR_W'(32'h1FFF_FFFF)
) (
   input  logic              cpu_clk_50M,
   input  logic              cpu_rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_tag,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [31:0]       data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata,
   input  logic              flush,
   output logic              resp_valid,
   output logic              resp_is_load,
   output logic [4:0]        resp_tag,
   output logic [31:0]       resp_rdata,
   output logic              exc_valid,
   output logic [4:0]        exc_code,
   output logic [ADDR_W-1:0] exc_badvaddr,
   output logic              busy
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t      state;
   logic [4:0]  tag_q;
   logic [2:0]  op_q;
   logic [1:0]  off_q;
   logic        kill_q;
   logic        fifo_full;
   logic        fifo_empty;
   logic        accept;
   logic        misaligned;
   logic        push;
   trk_entry_t  push_entry;
   trk_entry_t  head;

   assign req_ready  = !cpu_rst && (state == IDLE) && !fifo_full && !flush;
   assign busy       = !cpu_rst && ((state != IDLE) || !fifo_empty);
   assign data_req   = !cpu_rst && (state == ISSUE);
   assign accept     = req_valid & req_ready;
   assign misaligned = op_misaligned(req_op, req_addr[1:0]);
   assign push       = (state == ISSUE) & data_addr_ok;
   assign push_entry = '{tag: tag_q, op: op_q, off: off_q, kill: kill_q | flush};

   lsu_track_fifo #(
      .DEPTH (OUTSTANDING),
      .WIDTH (TRK_W)
   ) u_track (
      .clk       (cpu_clk_50M),
      .rst       (cpu_rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (data_data_ok),
      .kill_all  (flush),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         state        <= IDLE;
         tag_q        <= '0;
         op_q         <= '0;
         off_q        <= '0;
         kill_q       <= 1'b0;
         data_wr      <= 1'b0;
         data_size    <= '0;
         data_addr    <= '0;
         data_wdata   <= '0;
         resp_valid   <= 1'b0;
         resp_is_load <= 1'b0;
         resp_tag     <= '0;
         resp_rdata   <= '0;
         exc_valid    <= 1'b0;
         exc_code     <= '0;
         exc_badvaddr <= '0;
      end else begin
         resp_valid <= 1'b0;
         exc_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && misaligned) begin
                  exc_valid    <= !flush;
                  exc_code     <= op_is_store(req_op) ? EXC_ADES : EXC_ADEL;
                  exc_badvaddr <= req_addr;
               end else if (accept) begin
                  data_addr  <= req_addr & ADDR_MASK;
                  data_size  <= op_size(req_op);
                  data_wr    <= op_is_store(req_op);
                  data_wdata <= store_lanes(req_op, req_wdata);
                  tag_q      <= req_tag;
                  op_q       <= req_op;
                  off_q      <= req_addr[1:0];
                  kill_q     <= 1'b0;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               // A request cannot be retracted; a flush only marks it for silent drain
               if (flush) kill_q <= 1'b1;
               if (data_addr_ok) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (data_data_ok && !fifo_empty && !head.kill) begin
            resp_valid   <= 1'b1;
            resp_is_load <= !op_is_store(head.op);
            resp_tag     <= head.tag;
            resp_rdata   <= op_is_store(head.op) ? 32'd0 : load_align(head.op, head.off, data_rdata);
         end
      end
   end

endmodule

// File: tb/tb_mem_lsu_pipe.sv
// Directed bench for mem_lsu_pipe: stimulus queues expected responses/exceptions, a monitor checks them.
`timescale 1ns/1ps
module tb_mem_lsu_pipe;
   import lsu_pkg::*;

   logic        cpu_clk_50M = 1'b0;
   logic        cpu_rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_tag;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        flush;
   logic        resp_valid;
   logic        resp_is_load;
   logic [4:0]  resp_tag;
   logic [31:0] resp_rdata;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_badvaddr;
   logic        busy;

   typedef struct {
      logic        is_load;
      logic [4:0]  tag;
      logic [31:0] rdata;
   } resp_t;

   typedef struct {
      logic [4:0]  code;
      logic [31:0] vaddr;
   } exc_t;

   resp_t exp_resp[$];
   exc_t  exp_exc[$];
   int    passed = 0;
   int    total  = 0;

   mem_lsu_pipe dut (
      .cpu_clk_50M  (cpu_clk_50M),
      .cpu_rst      (cpu_rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_tag      (req_tag),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .flush        (flush),
      .resp_valid   (resp_valid),
      .resp_is_load (resp_is_load),
      .resp_tag     (resp_tag),
      .resp_rdata   (resp_rdata),
      .exc_valid    (exc_valid),
      .exc_code     (exc_code),
      .exc_badvaddr (exc_badvaddr),
      .busy         (busy)
   );

   always #5 cpu_clk_50M = ~cpu_clk_50M;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Monitor: every response/exception pulse must match the oldest queued expectation
   always @(negedge cpu_clk_50M) begin
      if (cpu_rst === 1'b0) begin
         if (resp_valid) begin
            if (exp_resp.size() == 0) begin
               total++;
               $display("FAIL unexpected_resp: got tag %0d rdata 0x%08h, expected none", resp_tag, resp_rdata);
            end else begin
               resp_t e;
               e = exp_resp.pop_front();
               chk("resp_is_load", 32'(resp_is_load), 32'(e.is_load));
               chk("resp_tag", 32'(resp_tag), 32'(e.tag));
               chk("resp_rdata", resp_rdata, e.rdata);
            end
         end
         if (exc_valid) begin
            if (exp_exc.size() == 0) begin
               total++;
               $display("FAIL unexpected_exc: got code %0d vaddr 0x%08h, expected none", exc_code, exc_badvaddr);
            end else begin
               exc_t x;
               x = exp_exc.pop_front();
               chk("exc_code", 32'(exc_code), 32'(x.code));
               chk("exc_badvaddr", exc_badvaddr, x.vaddr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge cpu_clk_50M);
      #1;
   endtask

   // Offer an op until accepted (bounded), then drop req_valid right after the accepting edge
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] tag);
      bit ok = 1'b0;
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = a;
      req_wdata = wd;
      req_tag   = tag;
      for (int i = 0; i < 20; i++) begin
         @(negedge cpu_clk_50M);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         total++;
         $display("FAIL issue_timeout: req_ready stayed 0 for op %0d addr 0x%08h", op, a);
      end
      tick();
      req_valid = 1'b0;
   endtask

   // Hold off data_addr_ok for 'hold' cycles, checking the request stays put, then accept it
   task automatic bus_accept(input int hold, input logic [31:0] a, input logic [1:0] sz,
                             input logic wr, input logic [31:0] wd);
      for (int i = 0; i < hold; i++) begin
         @(negedge cpu_clk_50M);
         chk("hold_data_req", 32'(data_req), 32'd1);
         chk("hold_data_addr", data_addr, a);
         tick();
      end
      data_addr_ok = 1'b1;
      @(negedge cpu_clk_50M);
      chk("data_req", 32'(data_req), 32'd1);
      chk("data_addr", data_addr, a);
      chk("data_size", 32'(data_size), 32'(sz));
      chk("data_wr", 32'(data_wr), 32'(wr));
      chk("data_wdata", data_wdata, wd);
      tick();
      data_addr_ok = 1'b0;
   endtask

   task automatic data_ok(input logic [31:0] r);
      data_data_ok = 1'b1;
      data_rdata   = r;
      tick();
      data_data_ok = 1'b0;
      data_rdata   = 32'd0;
   endtask

   initial begin
      cpu_rst      = 1'b1;
      req_valid    = 1'b0;
      req_op       = '0;
      req_addr     = '0;
      req_wdata    = '0;
      req_tag      = '0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = '0;
      flush        = 1'b0;

      // Reset: everything low during reset and on the cycle after, then req_ready rises
      tick();
      @(negedge cpu_clk_50M);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_data_req", 32'(data_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      tick();
      cpu_rst = 1'b0;
      @(negedge cpu_clk_50M);
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_data_req", 32'(data_req), 32'd0);
      chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("post_rst_exc_valid", 32'(exc_valid), 32'd0);
      tick();

      // LW through the address mask, bus stalls 3 cycles, data 2 cycles after acceptance
      exp_resp.push_back('{1'b1, 5'd3, 32'hDEAD_BEEF});
      issue(LSU_LW, 32'h8000_0010, 32'd0, 5'd3);
      bus_accept(3, 32'h0000_0010, SIZE_W, 1'b0, 32'd0);
      @(negedge cpu_clk_50M);
      chk("lw_busy_waiting", 32'(busy), 32'd1);
      tick();
      tick();
      data_ok(32'hDEAD_BEEF);
      tick();

      // Byte/half extraction with sign and zero extension
      exp_resp.push_back('{1'b1, 5'd1, 32'hFFFF_FF80});
      issue(LSU_LB, 32'h0000_0103, 32'd0, 5'd1);
      bus_accept(0, 32'h0000_0103, SIZE_B, 1'b0, 32'd0);
      data_ok(32'h8011_2233);
      exp_resp.push_back('{1'b1, 5'd2, 32'h0000_0080});
      issue(LSU_LBU, 32'h0000_0103, 32'd0, 5'd2);
      bus_accept(0, 32'h0000_0103, SIZE_B, 1'b0, 32'd0);
      data_ok(32'h8011_2233);
      exp_resp.push_back('{1'b1, 5'd4, 32'h0000_8011});
      issue(LSU_LHU, 32'h0000_0102, 32'd0, 5'd4);
      bus_accept(0, 32'h0000_0102, SIZE_H, 1'b0, 32'd0);
      data_ok(32'h8011_2233);

      // SH replicates the halfword; store response carries zero data
      exp_resp.push_back('{1'b0, 5'd7, 32'd0});
      issue(LSU_SH, 32'h0000_0202, 32'h1234_ABCD, 5'd7);
      bus_accept(1, 32'h0000_0202, SIZE_H, 1'b1, 32'hABCD_ABCD);
      data_ok(32'h5555_5555);
      tick();

      // Misaligned LW and SH: no bus access, one-cycle exception
      exp_exc.push_back('{EXC_ADEL, 32'h8000_0002});
      issue(LSU_LW, 32'h8000_0002, 32'd0, 5'd1);
      @(negedge cpu_clk_50M);
      chk("adel_no_data_req", 32'(data_req), 32'd0);
      chk("adel_not_busy", 32'(busy), 32'd0);
      tick();
      @(negedge cpu_clk_50M);
      chk("adel_exc_one_cycle", 32'(exc_valid), 32'd0);
      tick();
      exp_exc.push_back('{EXC_ADES, 32'h0000_0301});
      issue(LSU_SH, 32'h0000_0301, 32'hFFFF_0000, 5'd2);
      @(negedge cpu_clk_50M);
      chk("ades_no_data_req", 32'(data_req), 32'd0);
      tick();

      // Two in flight fill the tracker; third waits for a data_ok, responses stay in order
      exp_resp.push_back('{1'b1, 5'd10, 32'h1111_1111});
      issue(LSU_LW, 32'h0000_0100, 32'd0, 5'd10);
      bus_accept(0, 32'h0000_0100, SIZE_W, 1'b0, 32'd0);
      exp_resp.push_back('{1'b1, 5'd11, 32'hFFFF_8000});
      issue(LSU_LH, 32'h0000_0102, 32'd0, 5'd11);
      bus_accept(0, 32'h0000_0102, SIZE_H, 1'b0, 32'd0);
      exp_resp.push_back('{1'b1, 5'd12, 32'h0000_00AB});
      req_valid = 1'b1;
      req_op    = LSU_LBU;
      req_addr  = 32'h0000_0101;
      req_wdata = 32'd0;
      req_tag   = 5'd12;
      @(negedge cpu_clk_50M);
      chk("full_req_ready", 32'(req_ready), 32'd0);
      tick();
      @(negedge cpu_clk_50M);
      chk("full_req_ready_hold", 32'(req_ready), 32'd0);
      chk("full_no_data_req", 32'(data_req), 32'd0);
      tick();
      data_ok(32'h1111_1111);
      @(negedge cpu_clk_50M);
      chk("freed_req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      bus_accept(0, 32'h0000_0101, SIZE_B, 1'b0, 32'd0);
      data_ok(32'h8000_8000);
      data_ok(32'h0000_AB00);
      tick();

      // Flush with two loads in flight; a simultaneous request is refused
      issue(LSU_LW, 32'h0000_0400, 32'd0, 5'd20);
      bus_accept(0, 32'h0000_0400, SIZE_W, 1'b0, 32'd0);
      issue(LSU_LW, 32'h0000_0404, 32'd0, 5'd21);
      bus_accept(0, 32'h0000_0404, SIZE_W, 1'b0, 32'd0);
      data_data_ok = 1'b0;
      tick();
      flush     = 1'b1;
      req_valid = 1'b1;
      req_op    = LSU_LW;
      req_addr  = 32'h0000_0300;
      req_tag   = 5'd9;
      @(negedge cpu_clk_50M);
      chk("flush_req_ready", 32'(req_ready), 32'd0);
      tick();
      flush     = 1'b0;
      req_valid = 1'b0;
      data_ok(32'h1234_5678);
      @(negedge cpu_clk_50M);
      chk("drain_busy_mid", 32'(busy), 32'd1);
      tick();
      data_ok(32'h9ABC_DEF0);
      @(negedge cpu_clk_50M);
      chk("drain_busy_done", 32'(busy), 32'd0);
      tick();

      // Flush while a request is still waiting for address acceptance
      issue(LSU_LW, 32'h0000_0200, 32'd0, 5'd22);
      flush = 1'b1;
      @(negedge cpu_clk_50M);
      chk("flush_issue_req_held", 32'(data_req), 32'd1);
      tick();
      flush = 1'b0;
      bus_accept(1, 32'h0000_0200, SIZE_W, 1'b0, 32'd0);
      data_ok(32'h0BAD_0BAD);
      tick();

      // Normal operation resumes after the flush
      exp_resp.push_back('{1'b1, 5'd23, 32'hCAFE_F00D});
      issue(LSU_LW, 32'h0000_0204, 32'd0, 5'd23);
      bus_accept(0, 32'h0000_0204, SIZE_W, 1'b0, 32'd0);
      data_ok(32'hCAFE_F00D);

      repeat (4) tick();
      chk("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
      chk("exc_queue_drained", 32'(exp_exc.size()), 32'd0);
      chk("final_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_lsu_pipe.md
Name: mem_lsu_pipe

Overview:
- Pipelined load/store unit for the MEM stage of the miniMIPS32 core, driving the SRAM-like data bus (`data_req`/`data_addr_ok`/`data_data_ok`).
- Unlike a single-access blocking design, it honours `data_addr_ok`, keeps up to `OUTSTANDING` accesses in flight and aligns/extends load data itself.
- It also reports misalignment exceptions and supports pipeline flush with silent drain of in-flight accesses.

Parameters:
- ADDR_W, 32, width of virtual and physical address.
- OUTSTANDING, 2, maximum accepted-but-unanswered bus accesses; power of 2, at least 1.
- ADDR_MASK, 32'h1FFF_FFFF, AND-mask mapping virtual to physical address.

Ports:
- cpu_clk_50M  in  1  clock; all logic on its rising edge.
- cpu_rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  memory op offered by EX/MEM.
- req_ready  out  1  op accepted when `req_valid` & `req_ready`.
- req_op  in  3  LSU_LB/LBU/LH/LHU/LW/SB/SH/SW.
- req_addr  in  ADDR_W  virtual address.
- req_wdata  in  32  store source register.
- req_tag  in  5  destination register index, returned with the response.
- data_req  out  1  bus request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  ADDR_W  physical address, `req_addr & ADDR_MASK`.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted by the bus.
- data_data_ok  in  1  oldest in-flight access complete.
- data_rdata  in  32  load data, valid with `data_data_ok`.
- flush  in  1  exception/eret flush.
- resp_valid  out  1  completion pulse, loads and stores.
- resp_is_load  out  1
- resp_tag  out  5
- resp_rdata  out  32  aligned, sign/zero-extended load result; 0 for stores.
- exc_valid  out  1  misalignment pulse.
- exc_code  out  5  EXC_ADEL or EXC_ADES.
- exc_badvaddr  out  ADDR_W  offending virtual address.
- busy  out  1  issue FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (`cpu_rst` = 1 at a clock edge): FSM to IDLE, FIFO emptied.
- All outputs are 0 during reset and on the following cycle, except `req_ready`, which is 1 once out of reset.
- Issue FSM states: IDLE, ISSUE.
- `req_ready` = (state == IDLE) & !fifo_full.
- IDLE, accepted op, aligned: latch physical address, size, wr, wdata, tag, op → ISSUE.
- IDLE, accepted op, misaligned (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] ≠ 0): no bus access; stay IDLE.
  - Next cycle: `exc_valid` = 1 for exactly 1 cycle, `exc_code` = ADEL for loads / ADES for stores, `exc_badvaddr` = `req_addr`.
- ISSUE: `data_req` = 1; address, size, wr and wdata are held stable until `data_addr_ok`.
  - On `data_addr_ok`: push FIFO entry {tag, op, addr[1:0], kill = 0} → IDLE.
  - `data_req` is 0 in IDLE, so there is at most one new request per 2 cycles.
- Tracking FIFO: depth `OUTSTANDING`, circular pointers with wrap-around.
  - `data_data_ok` pops the head.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - `data_data_ok` while empty is ignored.
- Response: registered, 1 cycle after `data_data_ok` for a non-killed entry.
  - Load byte/half extraction is little-endian: byte k = `data_rdata[8k+7:8k]`, half = bytes {a+1, a}.
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Stores give `resp_valid` = 1, `resp_is_load` = 0, `resp_rdata` = 0.
- Store data lanes: SB = {4{b}}; SH = {2{h}}; SW = word.
- `flush`:
  - Sets kill on every FIFO entry.
  - In ISSUE, the request is not retracted (the bus protocol forbids it); it stays asserted until `data_addr_ok` and is pushed with kill = 1.
  - A simultaneous `req_valid` is not accepted (`req_ready` forced 0 that cycle).
  - Cancels a pending `exc_valid`.
- Killed entries pop on `data_data_ok` with no `resp_valid`.
- Reset mid-access abandons the FIFO; the bus is reset in the same domain.

Decomposition:
- Package `lsu_pkg`:
  - LSU_* op encodings and size codes.
  - EXC_ADEL/EXC_ADES (shared with the CP0 defines).
  - FIFO entry struct/width constant.
- One sub-module, `lsu_track_fifo`: parametrised depth/width, push/pop, flag-all-kill input, full/empty/head outputs.
- Load alignment/extension is a function in `lsu_pkg`.

Test Plan:
1. LW at 0x8000_0010, `data_addr_ok` after 3 cycles, `data_data_ok` 2 cycles later with rdata 0xDEADBEEF → `data_addr` = 0x0000_0010, `data_size` = 2, request held stable 3 cycles; `resp_rdata` = 0xDEADBEEF with tag.
2. LB at addr[1:0] = 3 with rdata 0x80112233 → `resp_rdata` = 0xFFFF_FF80; LBU at the same address → 0x0000_0080; LHU at addr[1:0] = 2 → 0x0000_8011.
3. SH of 0x1234ABCD at addr[1:0] = 2 → `data_wr` = 1, `data_size` = 1, `data_wdata` = 0xABCD_ABCD; response `resp_is_load` = 0.
4. LW at 0x8000_0002 → no `data_req`, `exc_valid` 1 cycle, `exc_code` = ADEL, `exc_badvaddr` = 0x8000_0002; SH at odd address → ADES.
5. OUTSTANDING = 2, `data_data_ok` withheld, three back-to-back loads → two issued, `req_ready` = 0; one `data_data_ok` → third accepted; responses returned in order.
6. Two loads in flight, `flush` pulsed → both `data_data_ok` arrive with no `resp_valid`; `busy` falls after the second; next op accepted normally.
